alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM
// encoding, requester-id width and the leading-zero helper.
package alu_pkg;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int OP_W    = 5;
  localparam int DATA_W  = 32;

  typedef logic [ID_W-1:0] req_id_t;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND  = 5'd0;
  localparam op_t OP_OR   = 5'd1;
  localparam op_t OP_ADD  = 5'd2;
  localparam op_t OP_SUB  = 5'd6;
  localparam op_t OP_SLTU = 5'd7;
  localparam op_t OP_NOR  = 5'd8;
  localparam op_t OP_XOR  = 5'd9;
  localparam op_t OP_CLO  = 5'd10;
  localparam op_t OP_CLZ  = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  // Leading-zero count, 0..32; leading ones are counted on the inverted word.
  function automatic logic [5:0] clz32(input logic [DATA_W-1:0] x);
    logic [5:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = DATA_W-1; i >= 0; i--) begin
      if (x[i])      hit = 1'b1;
      else if (!hit) n   = n + 6'd1;
    end
    return n;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients and the arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  op_t               req0_op,    req1_op;
  logic [DATA_W-1:0] req0_a,     req0_b;
  logic [DATA_W-1:0] req1_a,     req1_b;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_result, rsp_zero, rsp_err, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu.sv
// Purely combinational ALU; unsupported op codes give result 0 with o_err set.
module alu
  import alu_pkg::*;
(
  input  op_t               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_err
);

  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SLTU: o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_XOR:  o_result = i_a ^ i_b;
      OP_CLO:  o_result = {{(DATA_W-6){1'b0}}, clz32(~i_b)};
      OP_CLZ:  o_result = {{(DATA_W-6){1'b0}}, clz32(i_b)};
      default: o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single ALU: one transaction in flight,
// IDLE -> EXEC -> RESP, round-robin or fixed-priority grant.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  logic     [NUM_REQ-1:0] w_vld;
  logic     [NUM_REQ-1:0] w_rsp_rdy;
  logic     [NUM_REQ-1:0] w_gnt;
  alu_req_t [NUM_REQ-1:0] w_req;
  req_id_t                w_gnt_id;

  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_err;

  state_t               r_state;
  alu_req_t             r_req;
  req_id_t              r_id;
  req_id_t              r_ptr;
  logic [NUM_REQ-1:0]   r_rsp_vld;
  logic [DATA_W-1:0]    r_result;
  logic                 r_zero;
  logic                 r_err;
  logic                 r_busy;

  assign w_vld     = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_req[0]  = {bus.req0_op, bus.req0_a, bus.req0_b};
  assign w_req[1]  = {bus.req1_op, bus.req1_a, bus.req1_b};

  // r_ptr names the requester favoured on a tie; it flips away from whoever was last served.
  always_comb begin
    w_gnt_id = '0;
    if (&w_vld)        w_gnt_id = RR_EN ? r_ptr : req_id_t'(0);
    else if (w_vld[1]) w_gnt_id = req_id_t'(1);
    w_gnt = '0;
    if (rst_n && (r_state == ST_IDLE) && (|w_vld))
      w_gnt[w_gnt_id] = 1'b1;
  end

  alu u_alu (
    .i_op     (r_req.op),
    .i_a      (r_req.a),
    .i_b      (r_req.b),
    .o_result (w_alu_res),
    .o_err    (w_alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_rsp_vld <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_vld) begin
            r_req   <= w_req[w_gnt_id];
            r_id    <= w_gnt_id;
            r_state <= ST_EXEC;
            r_busy  <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_result        <= w_alu_res;
          r_zero          <= (w_alu_res == '0);
          r_err           <= w_alu_err;
          r_rsp_vld[r_id] <= 1'b1;
          r_state         <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_rdy[r_id]) begin
            r_rsp_vld <= '0;
            r_ptr     <= ~r_id;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_rsp_vld <= '0;
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];
  assign bus.rsp0_valid = r_rsp_vld[0];
  assign bus.rsp1_valid = r_rsp_vld[1];
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_err    = r_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus
// and checks both against a transaction-level model every cycle.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  s_v  = '0;
  logic [1:0]  s_rr = '0;
  logic [4:0]  s_op[2] = '{5'd0, 5'd0};
  logic [31:0] s_a[2]  = '{32'd0, 32'd0};
  logic [31:0] s_b[2]  = '{32'd0, 32'd0};

  logic [1:0]  o_rdy[2];
  logic [1:0]  o_vld[2];
  logic [31:0] o_res[2];
  logic        o_zero[2];
  logic        o_err[2];
  logic        o_busy[2];

  int n_vec = 0;
  int n_err = 0;

  // instance 0: round robin, instance 1: fixed priority
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_arbiter_if u_bus ();
    assign u_bus.req0_valid = s_v[0];
    assign u_bus.req1_valid = s_v[1];
    assign u_bus.req0_op    = s_op[0];
    assign u_bus.req1_op    = s_op[1];
    assign u_bus.req0_a     = s_a[0];
    assign u_bus.req0_b     = s_b[0];
    assign u_bus.req1_a     = s_a[1];
    assign u_bus.req1_b     = s_b[1];
    assign u_bus.rsp0_ready = s_rr[0];
    assign u_bus.rsp1_ready = s_rr[1];
    alu_arbiter #(.RR_EN(gi == 0)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_bus));
    assign o_rdy[gi]  = {u_bus.req1_ready, u_bus.req0_ready};
    assign o_vld[gi]  = {u_bus.rsp1_valid, u_bus.rsp0_valid};
    assign o_res[gi]  = u_bus.rsp_result;
    assign o_zero[gi] = u_bus.rsp_zero;
    assign o_err[gi]  = u_bus.rsp_err;
    assign o_busy[gi] = u_bus.busy;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lead(input logic [31:0] x, input logic bv);
    int n = 0;
    while (n < 32 && x[31-n] == bv) n++;
    return n;
  endfunction

  function automatic logic ref_err(input logic [4:0] op);
    return !(op inside {5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11});
  endfunction

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:  return a & b;
      5'd1:  return a | b;
      5'd2:  return a + b;
      5'd6:  return a - b;
      5'd7:  return (a < b) ? 32'd1 : 32'd0;
      5'd8:  return ~(a | b);
      5'd9:  return a ^ b;
      5'd10: return 32'(lead(b, 1'b1));
      5'd11: return 32'(lead(b, 1'b0));
      default: return 32'd0;
    endcase
  endfunction

  // transaction-level model: one op outstanding, age 0 = executing, 1 = response pending
  bit          m_busy[2];
  int          m_age[2];
  int          m_id[2];
  int          m_last[2] = '{1, 1};
  logic [31:0] m_res[2];
  bit          m_err[2];

  function automatic int pick(input int inst, input logic [1:0] v);
    if (v == 2'b11) return (inst == 0) ? ((m_last[0] == 0) ? 1 : 0) : 0;
    return v[0] ? 0 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_age[i]  <= 0;
        m_last[i] <= 1;
        m_res[i]  <= '0;
        m_err[i]  <= 1'b0;
      end else if (m_busy[i]) begin
        if (m_age[i] == 0) m_age[i] <= 1;
        else if (s_rr[m_id[i]]) begin
          m_busy[i] <= 1'b0;
          m_last[i] <= m_id[i];
        end
      end else if (s_v != 2'b00) begin
        m_busy[i] <= 1'b1;
        m_age[i]  <= 0;
        m_id[i]   <= pick(i, s_v);
        m_res[i]  <= ref_res(s_op[pick(i, s_v)], s_a[pick(i, s_v)], s_b[pick(i, s_v)]);
        m_err[i]  <= ref_err(s_op[pick(i, s_v)]);
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] er, ev;
    for (int i = 0; i < 2; i++) begin
      er = '0;
      ev = '0;
      if (rst_n && !m_busy[i] && s_v != 2'b00) er[pick(i, s_v)] = 1'b1;
      if (m_busy[i] && m_age[i] == 1) ev[m_id[i]] = 1'b1;
      chk($sformatf("ready[%0d]", i), 32'(o_rdy[i]), 32'(er));
      chk($sformatf("rsp_valid[%0d]", i), 32'(o_vld[i]), 32'(ev));
      chk($sformatf("busy[%0d]", i), 32'(o_busy[i]), 32'(m_busy[i]));
      if (ev != 2'b00) begin
        chk($sformatf("result[%0d]", i), o_res[i], m_res[i]);
        chk($sformatf("zero[%0d]", i), 32'(o_zero[i]), 32'(m_res[i] == 32'd0));
        chk($sformatf("err[%0d]", i), 32'(o_err[i]), 32'(m_err[i]));
      end
      if (!rst_n) begin
        chk($sformatf("rst_result[%0d]", i), o_res[i], 32'd0);
        chk($sformatf("rst_flags[%0d]", i), {30'd0, o_zero[i], o_err[i]}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int c0_fp, c1_fp, c0_rr, c1_rr;
  int ops[12] = '{0, 1, 2, 6, 7, 8, 9, 10, 11, 3, 4, 31};

  initial begin
    // reset: nothing accepted, outputs low
    s_v = 2'b11;
    repeat (2) tick();
    chk("reset_ready", 32'(o_rdy[0]), 32'd0);
    chk("reset_busy", 32'(o_busy[0]), 32'd0);
    chk("reset_result", o_res[0], 32'd0);
    s_v = 2'b00;
    s_rr = 2'b11;
    rst_n = 1'b1;
    tick();

    // single ADD from requester 0
    s_v = 2'b01; s_op[0] = 5'd2; s_a[0] = 32'd5; s_b[0] = 32'd7;
    #1 chk("add_ready", 32'(o_rdy[0]), 32'd1);
    tick();
    s_v = 2'b00;
    #1 chk("add_exec_valid", 32'(o_vld[0]), 32'd0);
    chk("add_exec_busy", 32'(o_busy[0]), 32'd1);
    tick();
    #1 chk("add_valid", 32'(o_vld[0]), 32'd1);
    chk("add_result", o_res[0], 32'd12);
    chk("add_flags", {30'd0, o_zero[0], o_err[0]}, 32'd0);
    tick();
    #1 chk("add_idle", 32'(o_busy[0]), 32'd0);

    // simultaneous requests straight after reset
    rst_n = 1'b0;
    tick();
    s_v = 2'b11;
    s_op[0] = 5'd6;  s_a[0] = 32'd3;      s_b[0] = 32'd3;
    s_op[1] = 5'd10; s_a[1] = 32'h1234;   s_b[1] = 32'h0000_FFFF;
    rst_n = 1'b1;
    #1 chk("tie_first_grant", 32'(o_rdy[0]), 32'd1);
    tick();
    s_v = 2'b10;
    tick();
    #1 chk("tie_rsp0_valid", 32'(o_vld[0]), 32'd1);
    chk("tie_rsp0_flags", {o_res[0], 1'b0} | 32'(o_zero[0]), 32'd1);
    tick();
    #1 chk("tie_second_grant", 32'(o_rdy[0]), 32'd2);
    tick();
    s_v = 2'b00;
    tick();
    #1 chk("tie_rsp1_valid", 32'(o_vld[0]), 32'd2);
    chk("tie_rsp1_result", o_res[0], 32'd0);
    chk("tie_rsp1_flags", {30'd0, o_zero[0], o_err[0]}, 32'd2);
    tick();

    // backpressure on requester 1 while requester 0 waits
    s_v = 2'b10; s_op[1] = 5'd2; s_a[1] = 32'd100; s_b[1] = 32'd23;
    s_rr = 2'b01;
    tick();
    s_v = 2'b01; s_op[0] = 5'd9; s_a[0] = 32'hF0; s_b[0] = 32'hFF;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_valid", 32'(o_vld[0]), 32'd2);
      chk("bp_result", o_res[0], 32'd123);
      chk("bp_no_ready", 32'(o_rdy[0]), 32'd0);
      tick();
    end
    s_rr = 2'b11;
    tick();
    #1 chk("bp_idle", 32'(o_busy[0]), 32'd0);
    chk("bp_waiter_kept", 32'(o_rdy[0]), 32'd1);
    tick();
    s_v = 2'b00;

    // reset while the XOR is executing
    #1 rst_n = 1'b0;
    #1 chk("rst_exec_result", o_res[0], 32'd0);
    chk("rst_exec_busy", 32'(o_busy[0]), 32'd0);
    chk("rst_exec_valid", 32'(o_vld[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    #1 chk("rst_dropped", 32'(o_vld[0]), 32'd0);
    s_v = 2'b10; s_op[1] = 5'd9; s_a[1] = 32'hF0; s_b[1] = 32'hFF;
    tick();
    s_v = 2'b00;
    tick();
    #1 chk("post_rst_result", o_res[0], 32'h0F);
    tick();

    // unsupported op
    s_v = 2'b01; s_op[0] = 5'd3; s_a[0] = 32'hDEAD; s_b[0] = 32'hBEEF;
    tick();
    s_v = 2'b00;
    tick();
    #1 chk("illegal_result", o_res[0], 32'd0);
    chk("illegal_flags", {30'd0, o_zero[0], o_err[0]}, 32'd3);
    tick();

    // both valid for four transactions
    s_v = 2'b11; s_op[0] = 5'd2; s_op[1] = 5'd1;
    c0_fp = 0; c1_fp = 0; c0_rr = 0; c1_rr = 0;
    repeat (12) begin
      #1;
      if (o_rdy[1][0]) c0_fp++;
      if (o_rdy[1][1]) c1_fp++;
      if (o_rdy[0][0]) c0_rr++;
      if (o_rdy[0][1]) c1_rr++;
      tick();
    end
    chk("fixed_req0_grants", 32'(c0_fp), 32'd4);
    chk("fixed_req1_grants", 32'(c1_fp), 32'd0);
    chk("rr_req0_grants", 32'(c0_rr), 32'd2);
    chk("rr_req1_grants", 32'(c1_rr), 32'd2);
    s_v = 2'b00;
    repeat (3) tick();

    // randomized traffic, checked by the compare process
    repeat (1500) begin
      rst_n = ($urandom_range(0, 199) != 0);
      s_v   = 2'($urandom_range(0, 3));
      s_rr  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      for (int r = 0; r < 2; r++) begin
        s_op[r] = 5'(ops[$urandom_range(0, 11)]);
        s_a[r]  = $urandom();
        case ($urandom_range(0, 3))
          0: s_b[r] = $urandom();
          1: s_b[r] = 32'hFFFF_FFFF >> $urandom_range(0, 32);
          2: s_b[r] = ~(32'hFFFF_FFFF >> $urandom_range(0, 32));
          default: s_b[r] = s_a[r];
        endcase
      end
      tick();
    end
    rst_n = 1'b1;
    s_v = 2'b00;
    s_rr = 2'b11;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
